id_ex_stage: RTL

- ID/EX pipeline register for the 5-stage MIPS core.
- Captures decode outputs: operands, extended immediate, register indices and control bits.
- Presents them to the EX stage: operand muxes, ALU, ALU control.
- Precomputes the EX-stage forwarding select codes (rega/regb) one cycle early, registering them alongside the instruction so the operand-B mux receives a clean registered select. Also flags load-use hazards to the hazard logic.

---
 rtl/id_ex_stage.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decode outputs, precomputes EX forwarding selects, flags load-use hazards.
// Latency: 1 cycle from ID inputs to registered outputs; o_load_use is combinational from registered state.
// Backpressure: i_stall freezes every register; i_flush (dominates stall) loads a bubble; optional ID_EX_BUBBLE_COUNT_EN adds o_bubble_count.
module id_ex_stage #(
  parameter int NBITS         = 32,
  parameter int NBITS_REG     = 5,
  parameter int NBITS_ALUOP   = 6,
  parameter int CORTOCIRCUITO = 3
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_stall,
  input  logic                     i_flush,
  input  logic                     i_valid,
  input  logic [NBITS-1:0]         i_pc4,
  input  logic [NBITS-1:0]         i_dato_ra,
  input  logic [NBITS-1:0]         i_dato_rb,
  input  logic [NBITS-1:0]         i_extension_data,
  input  logic [NBITS_REG-1:0]     i_rs,
  input  logic [NBITS_REG-1:0]     i_rt,
  input  logic [NBITS_REG-1:0]     i_rd,
  input  logic [NBITS_ALUOP-1:0]   i_ALUOp,
  input  logic                     i_ALUSrc,
  input  logic                     i_RegDst,
  input  logic                     i_MemRead,
  input  logic                     i_MemWrite,
  input  logic                     i_RegWrite,
  input  logic                     i_MemtoReg,
  input  logic                     i_ex_mem_RegWrite,
  input  logic [NBITS_REG-1:0]     i_ex_mem_rd,
  output logic                     o_valid,
  output logic [NBITS-1:0]         o_pc4,
  output logic [NBITS-1:0]         o_dato_ra,
  output logic [NBITS-1:0]         o_dato_rb,
  output logic [NBITS-1:0]         o_extension_data,
  output logic [NBITS_REG-1:0]     o_rs,
  output logic [NBITS_REG-1:0]     o_rt,
  output logic [NBITS_REG-1:0]     o_rd_dest,
  output logic [NBITS_ALUOP-1:0]   o_ALUOp,
  output logic                     o_ALUSrc,
  output logic                     o_MemRead,
  output logic                     o_MemWrite,
  output logic                     o_RegWrite,
  output logic                     o_MemtoReg,
  output logic [CORTOCIRCUITO-1:0] o_corto_circuito_rega,
  output logic [CORTOCIRCUITO-1:0] o_corto_circuito_regb,
  output logic                     o_load_use
`ifdef ID_EX_BUBBLE_COUNT_EN
  ,
  output logic [15:0]              o_bubble_count
`endif
);

  // Forwarding select encodings seen by the EX operand muxes.
  localparam logic [CORTOCIRCUITO-1:0] FWD_REG_FILE = CORTOCIRCUITO'(0);
  localparam logic [CORTOCIRCUITO-1:0] FWD_EX_MEM   = CORTOCIRCUITO'(1);
  localparam logic [CORTOCIRCUITO-1:0] FWD_MEM_WB   = CORTOCIRCUITO'(2);

  // Everything the stage carries, kept as one packed word so bubble/hold are single assignments.
  typedef struct packed {
    logic                     valid;
    logic [NBITS-1:0]         pc4;
    logic [NBITS-1:0]         dato_ra;
    logic [NBITS-1:0]         dato_rb;
    logic [NBITS-1:0]         extension_data;
    logic [NBITS_REG-1:0]     rs;
    logic [NBITS_REG-1:0]     rt;
    logic [NBITS_REG-1:0]     rd_dest;
    logic [NBITS_ALUOP-1:0]   alu_op;
    logic                     alu_src;
    logic                     mem_read;
    logic                     mem_write;
    logic                     reg_write;
    logic                     mem_to_reg;
    logic [CORTOCIRCUITO-1:0] fwd_a;
    logic [CORTOCIRCUITO-1:0] fwd_b;
  } stage_t;

  stage_t stage_q;
  stage_t stage_d;

  logic ex_mem_hit_a;
  logic ex_mem_hit_b;
  logic mem_wb_hit_a;
  logic mem_wb_hit_b;
  logic [CORTOCIRCUITO-1:0] fwd_a_nxt;
  logic [CORTOCIRCUITO-1:0] fwd_b_nxt;
  logic stage_en;

  // The instruction in EX/MEM next cycle is the one in this stage now, so it is the most recent producer.
  function automatic logic [CORTOCIRCUITO-1:0] fwd_code(input logic ex_hit, input logic mem_hit);
    if (ex_hit) begin
      return FWD_EX_MEM;
    end else if (mem_hit) begin
      return FWD_MEM_WB;
    end
    return FWD_REG_FILE;
  endfunction

  // Compare ID source fields against the current stage producer and the EX/MEM producer; r0 never forwards.
  always_comb begin
    ex_mem_hit_a = stage_q.valid && stage_q.reg_write &&
                   (stage_q.rd_dest != '0) && (stage_q.rd_dest == i_rs);
    ex_mem_hit_b = stage_q.valid && stage_q.reg_write &&
                   (stage_q.rd_dest != '0) && (stage_q.rd_dest == i_rt);
    mem_wb_hit_a = i_ex_mem_RegWrite && (i_ex_mem_rd != '0) && (i_ex_mem_rd == i_rs);
    mem_wb_hit_b = i_ex_mem_RegWrite && (i_ex_mem_rd != '0) && (i_ex_mem_rd == i_rt);
    fwd_a_nxt    = fwd_code(ex_mem_hit_a, mem_wb_hit_a);
    fwd_b_nxt    = fwd_code(ex_mem_hit_b, mem_wb_hit_b);
  end

  // Build the next stage word: a zero bubble on flush, otherwise the ID contents with controls gated by valid.
  always_comb begin
    stage_d = '0;
    if (!i_flush) begin
      stage_d.valid          = i_valid;
      stage_d.pc4            = i_pc4;
      stage_d.dato_ra        = i_dato_ra;
      stage_d.dato_rb        = i_dato_rb;
      stage_d.extension_data = i_extension_data;
      stage_d.rs             = i_rs;
      stage_d.rt             = i_rt;
      stage_d.rd_dest        = i_RegDst ? i_rd : i_rt;
      stage_d.alu_op         = i_valid ? i_ALUOp : '0;
      stage_d.alu_src        = i_valid & i_ALUSrc;
      stage_d.mem_read       = i_valid & i_MemRead;
      stage_d.mem_write      = i_valid & i_MemWrite;
      stage_d.reg_write      = i_valid & i_RegWrite;
      stage_d.mem_to_reg     = i_valid & i_MemtoReg;
      stage_d.fwd_a          = fwd_a_nxt;
      stage_d.fwd_b          = fwd_b_nxt;
    end
  end

  // Flush must take effect even while the pipeline is frozen.
  assign stage_en = i_flush || !i_stall;

  // Stage register: reset clears, otherwise update unless stalled.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      stage_q <= '0;
    end else if (stage_en) begin
      stage_q <= stage_d;
    end
  end

  // Load-use: a load in EX whose destination is read by the instruction in ID.
  always_comb begin
    o_load_use = 1'b0;
    if (i_reset && stage_q.valid && stage_q.mem_read && (stage_q.rd_dest != '0) &&
        ((stage_q.rd_dest == i_rs) || (stage_q.rd_dest == i_rt))) begin
      o_load_use = 1'b1;
    end
  end

  assign o_valid               = stage_q.valid;
  assign o_pc4                 = stage_q.pc4;
  assign o_dato_ra             = stage_q.dato_ra;
  assign o_dato_rb             = stage_q.dato_rb;
  assign o_extension_data      = stage_q.extension_data;
  assign o_rs                  = stage_q.rs;
  assign o_rt                  = stage_q.rt;
  assign o_rd_dest             = stage_q.rd_dest;
  assign o_ALUOp               = stage_q.alu_op;
  assign o_ALUSrc              = stage_q.alu_src;
  assign o_MemRead             = stage_q.mem_read;
  assign o_MemWrite            = stage_q.mem_write;
  assign o_RegWrite            = stage_q.reg_write;
  assign o_MemtoReg            = stage_q.mem_to_reg;
  assign o_corto_circuito_rega = stage_q.fwd_a;
  assign o_corto_circuito_regb = stage_q.fwd_b;

`ifdef ID_EX_BUBBLE_COUNT_EN
  logic        bubble_event;
  logic [15:0] bubble_count_q;

  // A bubble enters EX on a flush or on an unstalled load of an empty ID slot.
  assign bubble_event = i_flush || (!i_stall && !i_valid);

  // Saturating count of bubbles inserted since reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      bubble_count_q <= '0;
    end else if (bubble_event && (bubble_count_q != 16'hFFFF)) begin
      bubble_count_q <= bubble_count_q + 16'd1;
    end
  end

  assign o_bubble_count = bubble_count_q;
`endif

endmodule
